cpx_src_reqq: RTL

Source-side CPX request queue for one L2 bank, sitting directly upstream of the CPX buffer stages. It buffers return packets from the scache pipeline and tracks per-destination credits for the CPX per-source queues. It issues one-hot `req`/`atom` in the CQ cycle and drives packet data in the following CX cycle. Grants flowing back from the CPX return credits.

---
 rtl/cpx_src_reqq_if.sv | 30 +++
 rtl/cpx_src_reqq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpx_src_reqq_if.sv
// Bundle between the scache return pipeline, the CPX grant path and the
// source request queue.
interface cpx_src_reqq_if #(
    parameter int DW = 145
);
    logic          pkt_vld;
    logic [2:0]    pkt_dest;
    logic          pkt_atom;
    logic [DW-1:0] pkt_data;
    logic [7:0]    cpx_grant_ca;
    logic [7:0]    scache_cpx_req_cq;
    logic          scache_cpx_atom_cq;
    logic [DW-1:0] scache_cpx_data_cx;
    logic          scache_cpx_data_vld_cx;
    logic          q_full;
    logic          q_empty;
    logic          err;

    modport master (
        output pkt_vld, pkt_dest, pkt_atom, pkt_data, cpx_grant_ca,
        input  scache_cpx_req_cq, scache_cpx_atom_cq, scache_cpx_data_cx,
               scache_cpx_data_vld_cx, q_full, q_empty, err
    );

    modport slave (
        input  pkt_vld, pkt_dest, pkt_atom, pkt_data, cpx_grant_ca,
        output scache_cpx_req_cq, scache_cpx_atom_cq, scache_cpx_data_cx,
               scache_cpx_data_vld_cx, q_full, q_empty, err
    );
endinterface

// File: rtl/cpx_src_reqq.sv
// Source-side CPX request queue: in-order packet FIFO with per-cpu credits.
// Define CPX_SRC_ATOM_EN to enable atomic-pair issue (ATOM2 state, atom output).
module cpx_src_reqq #(
    parameter int DW     = 145,
    parameter int QDEPTH = 4,
    parameter int CRED   = 2
) (
    input logic           rclk,
    input logic           reset,
    cpx_src_reqq_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(CRED + 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CRED);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(QDEPTH);

    typedef enum logic {
        IDLE
`ifdef CPX_SRC_ATOM_EN
        , ATOM2
`endif
    } state_t;

    logic [2:0]    q_dest [QDEPTH];
    logic [DW-1:0] q_data [QDEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [CW-1:0] credit     [8];
    logic [CW-1:0] credit_nxt [8];
    state_t        state;
    state_t        state_nxt;

    logic          full_now;
    logic          head_vld;
    logic          enq;
    logic          issue;
    logic [2:0]    head_dest;
    logic [2:0]    issue_dest;
    logic [1:0]    take;
    logic          seq_err;
    logic          grant_err;

    logic [7:0]    req_p0;
    logic          vld_p0;
    logic [DW-1:0] data_p0;
    logic          vld_p1;
    logic [DW-1:0] data_p1;
    logic          full_r;
    logic          empty_r;
    logic          err_r;

`ifdef CPX_SRC_ATOM_EN
    logic          q_atom [QDEPTH];
    logic          head_atom;
    logic          issue_atom;
    logic          atom_p0;
    logic [2:0]    atom_dest;
    assign head_atom = q_atom[head];
`else
    logic          atom_unused;
    assign atom_unused = bus.pkt_atom;
`endif

    assign full_now  = (count == DEPTH_CNT);
    assign head_vld  = (count != '0);
    assign enq       = bus.pkt_vld && !full_now;
    assign head_dest = q_dest[head];
    assign count_nxt = count + (AW + 1)'(enq) - (AW + 1)'(issue);

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_dest = head_dest;
        take       = 2'd0;
        seq_err    = 1'b0;
`ifdef CPX_SRC_ATOM_EN
        issue_atom = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (head_vld) begin
`ifdef CPX_SRC_ATOM_EN
                    // First half reserves the credit of its partner as well.
                    if (head_atom) begin
                        if (int'(credit[head_dest]) >= 2) begin
                            issue      = 1'b1;
                            issue_atom = 1'b1;
                            take       = 2'd2;
                            state_nxt  = ATOM2;
                        end
                    end else if (credit[head_dest] != '0) begin
                        issue = 1'b1;
                        take  = 2'd1;
                    end
`else
                    if (credit[head_dest] != '0) begin
                        issue = 1'b1;
                        take  = 2'd1;
                    end
`endif
                end
            end
`ifdef CPX_SRC_ATOM_EN
            ATOM2: begin
                if (head_vld) begin
                    issue      = 1'b1;
                    issue_dest = atom_dest;
                    seq_err    = (head_dest != atom_dest);
                    state_nxt  = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_err = 1'b0;
        for (int d = 0; d < 8; d++) begin
            credit_nxt[d] = credit[d];
            if (bus.cpx_grant_ca[d]) begin
                if (credit[d] == CRED_MAX) grant_err = 1'b1;
                else credit_nxt[d] = credit_nxt[d] + CW'(1);
            end
            if (issue && (issue_dest == 3'(d))) credit_nxt[d] = credit_nxt[d] - CW'(take);
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            state   <= IDLE;
            for (int d = 0; d < 8; d++) credit[d] <= CRED_MAX;
            err_r   <= 1'b0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            req_p0  <= 8'd0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
`ifdef CPX_SRC_ATOM_EN
            atom_p0 <= 1'b0;
`endif
        end else begin
            head    <= head + AW'(issue);
            tail    <= tail + AW'(enq);
            count   <= count_nxt;
            state   <= state_nxt;
            for (int d = 0; d < 8; d++) credit[d] <= credit_nxt[d];
            err_r   <= err_r | (bus.pkt_vld & full_now) | grant_err | seq_err;
            full_r  <= (count_nxt == DEPTH_CNT);
            empty_r <= (count_nxt == '0);
            // CQ stage: request pulse
            req_p0  <= issue ? (8'd1 << issue_dest) : 8'd0;
            vld_p0  <= issue;
`ifdef CPX_SRC_ATOM_EN
            atom_p0 <= issue_atom;
`endif
            // CX stage: payload follows its request by one cycle
            vld_p1  <= vld_p0;
            if (vld_p0) data_p1 <= data_p0;
        end
    end

    always_ff @(posedge rclk) begin
        if (enq) begin
            q_dest[tail] <= bus.pkt_dest;
            q_data[tail] <= bus.pkt_data;
`ifdef CPX_SRC_ATOM_EN
            q_atom[tail] <= bus.pkt_atom;
`endif
        end
        if (issue) data_p0 <= q_data[head];
`ifdef CPX_SRC_ATOM_EN
        if (issue_atom) atom_dest <= head_dest;
`endif
    end

    assign bus.scache_cpx_req_cq      = req_p0;
`ifdef CPX_SRC_ATOM_EN
    assign bus.scache_cpx_atom_cq     = atom_p0;
`else
    assign bus.scache_cpx_atom_cq     = 1'b0;
`endif
    assign bus.scache_cpx_data_cx     = data_p1;
    assign bus.scache_cpx_data_vld_cx = vld_p1;
    assign bus.q_full                 = full_r;
    assign bus.q_empty                = empty_r;
    assign bus.err                    = err_r;
endmodule
